// File: rtl/inst_mem_responder.sv
// Byte-programmable instruction memory with a one-deep valid/ready fetch responder.
// Define IMEM_ALIGN_CHECK_EN to turn misaligned fetches into error responses.
module inst_mem_responder #(
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_BITS   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [31:0]          fetch_addr,
    input  logic                 inst_ready,
    output logic                 inst_valid,
    output logic [31:0]          inst_data,
    output logic                 fetch_err,
    input  logic                 prog_en,
    input  logic                 prog_we,
    input  logic [ADDR_BITS-1:0] prog_addr,
    input  logic [7:0]           prog_wdata
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {IDLE, RESP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem_q [DEPTH_BYTES];
    logic [31:0]    data_q, data_d;
    logic           err_q, err_d;
    logic           accept;
    logic           addr_bad;
    logic [ADDR_BITS-1:0] base;
    logic [31:0]    rd_word;

    // Without the alignment check the low address bits are masked off, so 2044..2047 never wrap.
    always_comb begin
        addr_bad = |fetch_addr[31:ADDR_BITS];
`ifdef IMEM_ALIGN_CHECK_EN
        addr_bad = addr_bad | (|fetch_addr[1:0]);
`else
        addr_bad = addr_bad;
`endif
        base    = fetch_addr[ADDR_BITS-1:0] & ~ADDR_BITS'(3);
        rd_word = {mem_q[base | ADDR_BITS'(3)], mem_q[base | ADDR_BITS'(2)],
                   mem_q[base | ADDR_BITS'(1)], mem_q[base]};
    end

    // Reset blocks writes but never clears contents.
    always_ff @(posedge clk) begin
        if (prog_en && prog_we && !rst) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        accept = fetch_req && !prog_en && ((state_q == IDLE) || inst_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP: if (inst_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            err_d  = addr_bad;
            data_d = addr_bad ? NOP : rd_word;
        end
    end

    always_comb begin
        inst_valid = (state_q == RESP);
        inst_data  = data_q;
        fetch_err  = err_q;
    end

endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter: DEPTH_BYTES, 2048, instruction storage in bytes (512 x 32-bit instructions).
REQ-002 Parameter: ADDR_BITS, 11, in-range byte address width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: fetch_req  input  1  fetch request qualifier for fetch_addr.
REQ-006 Port: fetch_addr  input  32  byte address of requested instruction (program counter output).
REQ-007 Port: inst_ready  input  1  consumer accepts the current response.
REQ-008 Port: inst_valid  output  1  inst_data / fetch_err hold a response.
REQ-009 Port: inst_data  output  32  fetched instruction, little-endian.
REQ-010 Port: fetch_err  output  1  response belongs to an illegal address.
REQ-011 Port: prog_en  input  1  programming mode; blocks new fetches.
REQ-012 Port: prog_we  input  1  byte write strobe, honoured only when prog_en=1.
REQ-013 Port: prog_addr  input  11  byte address for programming writes.
REQ-014 Port: prog_wdata  input  8  byte to write.

Function
REQ-015 Storage SHALL be DEPTH_BYTES bytes; the word at byte address A SHALL be {mem[A+3],mem[A+2],mem[A+1],mem[A]}.
REQ-016 FSM SHALL have states IDLE and RESP; no other states.
REQ-017 In IDLE with fetch_req=1 and prog_en=0, the request SHALL be captured; on the next cycle inst_valid=1 and the state SHALL be RESP (latency 1).
REQ-018 In IDLE with prog_en=1, fetch_req SHALL be ignored and no response SHALL be generated.
REQ-019 In RESP, inst_valid, inst_data and fetch_err SHALL stay stable until a cycle with inst_ready=1.
REQ-020 In RESP with inst_ready=1, fetch_req=1 and prog_en=0, the new request SHALL be captured back-to-back: inst_valid stays 1 and new data appears the next cycle.
REQ-021 In RESP with inst_ready=1 and no new accepted request, the next state SHALL be IDLE with inst_valid=0.
REQ-022 fetch_addr[31:11] != 0 SHALL produce a response with fetch_err=1 and inst_data=32'h00000013 (NOP).
REQ-023 A fetch at byte address 2044..2047 with unaligned offset SHALL not wrap; it is governed by REQ-032.
REQ-024 With prog_en=1 and prog_we=1, prog_wdata SHALL be written to mem[prog_addr] at the clock edge, in any state.
REQ-025 Response data SHALL be read at capture time; a later write to the same address SHALL not change a pending response.
REQ-026 prog_en rising during RESP SHALL not drop the pending response; it completes per REQ-019/021.

Reset
REQ-027 rst=1 SHALL force state IDLE, inst_valid=0, fetch_err=0, inst_data=32'h00000000 on the next edge.
REQ-028 Reset mid-RESP SHALL discard the pending response; reset SHALL dominate fetch_req and prog_we in the same cycle.
REQ-029 Memory contents SHALL not be cleared by reset.

Configuration
REQ-030 Macro IMEM_ALIGN_CHECK_EN SHALL enable alignment checking.
REQ-031 Defined: fetch_addr[1:0] != 0 SHALL yield fetch_err=1 and inst_data=32'h00000013.
REQ-032 Undefined: fetch_addr[1:0] SHALL be treated as 2'b00, with no error.

Verification
REQ-033 Program bytes 0x93,0x00,0x10,0x00 at 0..3, then fetch 0x0 with inst_ready=1 -> one cycle later inst_valid=1, inst_data=32'h00100093, fetch_err=0.
REQ-034 Fetch 0x4 with inst_ready=0 for 3 cycles -> inst_valid and inst_data held constant, then drop one cycle after inst_ready=1.
REQ-035 Back-to-back fetches 0x0, 0x4, 0x8 with inst_ready=1 -> inst_valid stays 1 continuously and the data sequence matches the programmed words.
REQ-036 Fetch 0x00000800 -> fetch_err=1, inst_data=32'h00000013; fetch 0x2 -> error with macro defined, word at 0x0 without it.
REQ-037 rst=1 asserted during RESP -> inst_valid=0 next cycle, and a subsequent fetch of 0x0 still returns the programmed data.
